// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset sequencing, lock supervision and system reset release.
// Define PLL_RST_CTRL_SOFT_RESET_EN to add the soft_rst_in re-sequence input.
module pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4
) (
  input  logic       clock_in,
  input  logic       rst_n_in,
  input  logic       locked_in,
`ifdef PLL_RST_CTRL_SOFT_RESET_EN
  input  logic       soft_rst_in,
`endif
  output logic       pll_rst_out,
  output logic       sys_rst_n_out,
  output logic       ready_out,
  output logic [7:0] retry_count_out,
  output logic       fault_out
);

  localparam int MAX_AB =
    (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
    PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C =
    (MAX_AB > STABLE_CYCLES) ?
    MAX_AB : STABLE_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] RST_LAST =
    CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST =
    CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sync1;
  logic            r_lock_s;

  logic [7:0]      w_retry_inc;
  logic            w_to_fault;
  logic            w_soft;

  // locked_in is asynchronous to clock_in
  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= locked_in;
      r_lock_s <= r_sync1;
    end
  end

  assign w_retry_inc =
    (retry_count_out == 8'hFF) ?
    retry_count_out : retry_count_out + 8'd1;

  assign w_to_fault =
    (MAX_RETRIES != 0) &&
    ({24'd0, w_retry_inc} == MAX_RETRIES);

`ifdef PLL_RST_CTRL_SOFT_RESET_EN
  assign w_soft =
    soft_rst_in && (r_state != S_FAULT);
`else
  assign w_soft = 1'b0;
`endif

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state         <= S_RESET_PLL;
      r_cnt           <= '0;
      pll_rst_out     <= 1'b1;
      sys_rst_n_out   <= 1'b0;
      ready_out       <= 1'b0;
      retry_count_out <= 8'd0;
      fault_out       <= 1'b0;
    end else if (w_soft) begin
      // held with a cleared count until the request drops
      r_state       <= S_RESET_PLL;
      r_cnt         <= '0;
      pll_rst_out   <= 1'b1;
      sys_rst_n_out <= 1'b0;
      ready_out     <= 1'b0;
    end else begin
      unique case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            pll_rst_out <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_cnt           <= '0;
            retry_count_out <= w_retry_inc;
            pll_rst_out     <= 1'b1;
            if (w_to_fault) begin
              r_state   <= S_FAULT;
              fault_out <= 1'b1;
            end else begin
              r_state <= S_RESET_PLL;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == ST_LAST) begin
            r_state       <= S_RUN;
            r_cnt         <= '0;
            sys_rst_n_out <= 1'b1;
            ready_out     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            r_cnt           <= '0;
            retry_count_out <= w_retry_inc;
            pll_rst_out     <= 1'b1;
            sys_rst_n_out   <= 1'b0;
            ready_out       <= 1'b0;
            if (w_to_fault) begin
              r_state   <= S_FAULT;
              fault_out <= 1'b1;
            end else begin
              r_state <= S_RESET_PLL;
            end
          end
        end
        S_FAULT: begin
          r_cnt <= '0;
        end
        default: begin
          r_state       <= S_RESET_PLL;
          r_cnt         <= '0;
          pll_rst_out   <= 1'b1;
          sys_rst_n_out <= 1'b0;
          ready_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: vector table, corner sequences and random lock
// stimulus against an elapsed-time reference model.
module tb_pll_reset_ctrl;

  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int SC  = 8;
  localparam int MR  = 3;
`ifdef PLL_RST_CTRL_SOFT_RESET_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       locked = 1'b0;
`ifdef PLL_RST_CTRL_SOFT_RESET_EN
  logic       soft = 1'b0;
`endif
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] retry;
  logic       fault;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT(LTO),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR)
  ) dut (
    .clock_in(clk),
    .rst_n_in(rst_n),
    .locked_in(locked),
`ifdef PLL_RST_CTRL_SOFT_RESET_EN
    .soft_rst_in(soft),
`endif
    .pll_rst_out(pll_rst),
    .sys_rst_n_out(sys_rst_n),
    .ready_out(ready),
    .retry_count_out(retry),
    .fault_out(fault)
  );

  // reference model: phase plus the cycle on which it was entered
  typedef enum {
    PH_PLLRST, PH_WAIT, PH_STABLE, PH_RUN, PH_FAULT
  } ph_e;

  ph_e m_ph;
  int  m_cyc;
  int  m_t0;
  int  m_retry;
  bit  m_q[$];

  function automatic logic [11:0] pack(
    bit p, bit s, bit r, int rc, bit f);
    return {p, s, r, 8'(rc), f};
  endfunction

  function automatic logic [11:0] model_out();
    bit hold_pll;
    hold_pll = (m_ph == PH_PLLRST) ||
               (m_ph == PH_FAULT);
    return pack(hold_pll, m_ph == PH_RUN,
                m_ph == PH_RUN, m_retry,
                m_ph == PH_FAULT);
  endfunction

  function automatic void model_reset();
    m_ph = PH_PLLRST;
    m_cyc = 0;
    m_t0 = 0;
    m_retry = 0;
    m_q.delete();
  endfunction

  function automatic void model_lock_fail();
    m_retry = (m_retry < 255) ? m_retry + 1 : 255;
    m_t0 = m_cyc;
    if (MR != 0 && m_retry == MR) m_ph = PH_FAULT;
    else m_ph = PH_PLLRST;
  endfunction

  function automatic void model_step(bit lk, bit sf);
    bit ls;
    int el;
    m_cyc++;
    m_q.push_back(lk);
    if (m_q.size() > 3) void'(m_q.pop_front());
    ls = (m_q.size() == 3) ? m_q[0] : 1'b0;
    el = m_cyc - m_t0;
    if (SOFT_EN && sf && m_ph != PH_FAULT) begin
      m_ph = PH_PLLRST;
      m_t0 = m_cyc;
    end else begin
      case (m_ph)
        PH_PLLRST:
          if (el >= PRC) begin
            m_ph = PH_WAIT; m_t0 = m_cyc;
          end
        PH_WAIT:
          if (ls) begin
            m_ph = PH_STABLE; m_t0 = m_cyc;
          end else if (el >= LTO) begin
            model_lock_fail();
          end
        PH_STABLE:
          if (!ls) begin
            m_ph = PH_WAIT; m_t0 = m_cyc;
          end else if (el >= SC) begin
            m_ph = PH_RUN; m_t0 = m_cyc;
          end
        PH_RUN:
          if (!ls) model_lock_fail();
        default: ;
      endcase
    end
  endfunction

  task automatic check(string name, logic [11:0] exp);
    logic [11:0] act;
    act = {pll_rst, sys_rst_n, ready, retry, fault};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pll=%0b sys=%0b rdy=%0b retry=%0d fault=%0b, want pll=%0b sys=%0b rdy=%0b retry=%0d fault=%0b",
               name, act[11], act[10], act[9], act[8:1], act[0],
               exp[11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  task automatic step(bit lk, bit sf);
    locked = lk;
`ifdef PLL_RST_CTRL_SOFT_RESET_EN
    soft = sf;
`endif
    @(posedge clk);
    model_step(lk, sf);
    #1;
    check($sformatf("model cyc%0d", m_cyc), model_out());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst", pack(1, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit rst; bit lk; bit sf; int n;
    bit p; bit s; bit r; int rc; bit f;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    bit rst, bit lk, bit sf, int n,
    bit p, bit s, bit r, int rc, bit f);
    vec_t v;
    v = '{rst, lk, sf, n, p, s, r, rc, f};
    vecs.push_back(v);
  endfunction

  initial begin
    // startup, then lock loss in RUN
    add(1, 0, 0,  3, 1, 0, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0,  5, 0, 0, 0, 0, 0);
    add(0, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0,  9, 0, 0, 0, 0, 0);
    add(0, 1, 0,  1, 0, 1, 1, 0, 0);
    add(0, 0, 0,  1, 0, 1, 1, 0, 0);
    add(0, 0, 0,  2, 1, 0, 0, 1, 0);
    add(0, 0, 0,  4, 0, 0, 0, 1, 0);
    add(0, 0, 0,  2, 0, 0, 0, 1, 0);
    add(0, 1, 0, 10, 0, 0, 0, 1, 0);
    add(0, 1, 0,  1, 0, 1, 1, 1, 0);
    // async reset from RUN, then a glitch in STABLE
    add(1, 0, 0,  9, 0, 0, 0, 0, 0);
    add(0, 1, 0,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0,  4, 0, 0, 0, 0, 0);
    add(0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 10, 0, 0, 0, 0, 0);
    add(0, 1, 0,  1, 0, 1, 1, 0, 0);
    // lock never comes: retries then fault
    add(1, 0, 0, 23, 0, 0, 0, 0, 0);
    add(0, 0, 0,  1, 1, 0, 0, 1, 0);
    add(0, 0, 0,  4, 0, 0, 0, 1, 0);
    add(0, 0, 0, 20, 1, 0, 0, 2, 0);
    add(0, 0, 0, 23, 0, 0, 0, 2, 0);
    add(0, 0, 0,  1, 1, 0, 0, 3, 1);
    add(0, 1, 0, 50, 1, 0, 0, 3, 1);
    if (SOFT_EN) begin
      add(1, 0, 0,  9, 0, 0, 0, 0, 0);
      add(0, 1, 0, 11, 0, 1, 1, 0, 0);
      add(0, 1, 1,  1, 1, 0, 0, 0, 0);
      add(0, 1, 1,  2, 1, 0, 0, 0, 0);
      add(0, 1, 0,  3, 1, 0, 0, 0, 0);
      add(0, 1, 0,  1, 0, 0, 0, 0, 0);
    end

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      repeat (vecs[i].n) step(vecs[i].lk, vecs[i].sf);
      check($sformatf("vec%0d", i),
            pack(vecs[i].p, vecs[i].s, vecs[i].r,
                 vecs[i].rc, vecs[i].f));
    end

    // lock loss on the same edge the stable count expires
    do_reset();
    repeat (9) step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    check("loss_pre", pack(0, 0, 0, 0, 0));
    step(1'b0, 1'b0);
    check("loss_wins", pack(0, 0, 0, 0, 0));

    // random lock behaviour
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int c = 0; c < 500; ) begin
        int len;
        bit lk;
        bit sf;
        len = $urandom_range(1, 30);
        lk = ($urandom_range(0, 3) != 0);
        for (int j = 0; j < len && c < 500; j++) begin
          sf = SOFT_EN && ($urandom_range(0, 60) == 0);
          step(lk, sf);
          c++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
